// File: rtl/oam_dma_bus_bridge_pkg.sv
// Shared constants, FSM encoding and source-page mapping for the OAM DMA bus bridge.
// Optional build macro: OAM_DMA_ECHO_MIRROR_EN (maps DMA source pages E0-FF down by 8'h20).
package oam_dma_bus_bridge_pkg;

    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    localparam int          DMA_LEN      = 160;
    localparam int          START_DELAY  = 4;
    localparam logic [7:0]  DMA_LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [2:0]  START_LAST   = 3'(START_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_e;

    function automatic logic [7:0] dma_src_map(input logic [7:0] src);
`ifdef OAM_DMA_ECHO_MIRROR_EN
        // Echo RAM pages alias the work RAM 8 KiB below them.
        if (src >= 8'hE0) begin
            return src - 8'h20;
        end else begin
            return src;
        end
`else
        return src;
`endif
    endfunction

endpackage

// File: rtl/oam_dma_bus_bridge_if.sv
// CPU-side, external-bus and OAM-side signals of the bridge; slave = bridge view, master = driver view.
interface oam_dma_bus_bridge_if;

    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic [15:0] ext_a;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        ext_rd;
    logic        ext_wr;
    logic [7:0]  oam_a;
    logic [7:0]  oam_dout;
    logic        oam_we;
    logic        dma_active;

    modport slave (
        input  cpu_a, cpu_dout, cpu_rd, cpu_wr, ext_din,
        output cpu_din, ext_a, ext_dout, ext_rd, ext_wr,
        output oam_a, oam_dout, oam_we, dma_active
    );

    modport master (
        output cpu_a, cpu_dout, cpu_rd, cpu_wr, ext_din,
        input  cpu_din, ext_a, ext_dout, ext_rd, ext_wr,
        input  oam_a, oam_dout, oam_we, dma_active
    );

endinterface

// File: rtl/oam_dma_bus_bridge_hram_127x8.sv
// 127x8 high RAM: synchronous write, asynchronous read; contents are never reset.
module hram_127x8 (
    input  logic       clk,
    input  logic       we_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:126];

    // Storage write port; index 7F (FFFF) is never a valid HRAM location.
    always_ff @(posedge clk) begin
        if (we_i && (addr_i != 7'h7F)) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Asynchronous read port.
    always_comb begin
        if (addr_i == 7'h7F) begin
            rdata_o = 8'h00;
        end else begin
            rdata_o = mem_q[addr_i];
        end
    end

endmodule

// File: rtl/oam_dma_bus_bridge.sv
// CPU bus bridge: HRAM/external decode plus the FF46-triggered OAM DMA engine.
// Optional build macro: OAM_DMA_ECHO_MIRROR_EN (see package dma_src_map).
module oam_dma_bus_bridge
    import oam_dma_bus_bridge_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    oam_dma_bus_bridge_if.slave bus
);

    dma_state_e  state_q;
    logic [2:0]  dly_q;
    logic [7:0]  idx_q;
    logic [1:0]  phase_q;
    logic [7:0]  src_q;
    logic [7:0]  latch_q;
    logic [15:0] dma_addr_q;
    logic        dma_rd_q;
    logic [7:0]  oam_a_q;
    logic [7:0]  oam_dout_q;
    logic        oam_we_q;
    logic        dma_active_q;

    logic        hit_hram_s;
    logic        hit_reg_s;
    logic        trig_s;
    logic        hram_we_s;
    logic [7:0]  idx_next_s;
    logic [7:0]  src_eff_s;
    logic [7:0]  hram_rdata_s;

    hram_127x8 u_hram (
        .clk     (clk),
        .we_i    (hram_we_s),
        .addr_i  (bus.cpu_a[6:0]),
        .wdata_i (bus.cpu_dout),
        .rdata_o (hram_rdata_s)
    );

    // Address decode and DMA helper values.
    always_comb begin
        hit_hram_s = (bus.cpu_a >= HRAM_LO) && (bus.cpu_a <= HRAM_HI);
        hit_reg_s  = (bus.cpu_a == DMA_REG_ADDR);
        trig_s     = bus.cpu_wr && hit_reg_s;
        hram_we_s  = bus.cpu_wr && hit_hram_s;
        idx_next_s = idx_q + 8'd1;
        src_eff_s  = dma_src_map(src_q);
    end

    // DMA FSM; a trigger write restarts the engine from any state, even on the final byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dly_q        <= 3'd0;
            idx_q        <= 8'd0;
            phase_q      <= 2'd0;
            src_q        <= 8'h00;
            latch_q      <= 8'h00;
            dma_addr_q   <= 16'h0000;
            dma_rd_q     <= 1'b0;
            oam_a_q      <= 8'h00;
            oam_dout_q   <= 8'h00;
            oam_we_q     <= 1'b0;
            dma_active_q <= 1'b0;
        end else if (trig_s) begin
            state_q      <= ST_START;
            src_q        <= bus.cpu_dout;
            dly_q        <= 3'd0;
            idx_q        <= 8'd0;
            phase_q      <= 2'd0;
            dma_rd_q     <= 1'b0;
            oam_we_q     <= 1'b0;
            dma_active_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dma_rd_q     <= 1'b0;
                    oam_we_q     <= 1'b0;
                    dma_active_q <= 1'b0;
                end
                ST_START: begin
                    if (dly_q == START_LAST) begin
                        state_q    <= ST_XFER;
                        phase_q    <= 2'd0;
                        dma_addr_q <= {src_eff_s, idx_q};
                        dma_rd_q   <= 1'b1;
                    end else begin
                        dly_q <= dly_q + 3'd1;
                    end
                end
                ST_XFER: begin
                    case (phase_q)
                        2'd0: begin
                            phase_q <= 2'd1;
                        end
                        2'd1: begin
                            // Source data has had two clk to settle behind ext_rd.
                            latch_q  <= bus.ext_din;
                            dma_rd_q <= 1'b0;
                            phase_q  <= 2'd2;
                        end
                        2'd2: begin
                            oam_a_q    <= idx_q;
                            oam_dout_q <= latch_q;
                            oam_we_q   <= 1'b1;
                            phase_q    <= 2'd3;
                        end
                        default: begin
                            oam_we_q <= 1'b0;
                            phase_q  <= 2'd0;
                            if (idx_q == DMA_LAST_IDX) begin
                                state_q      <= ST_IDLE;
                                dma_active_q <= 1'b0;
                            end else begin
                                idx_q      <= idx_next_s;
                                dma_addr_q <= {src_eff_s, idx_next_s};
                                dma_rd_q   <= 1'b1;
                            end
                        end
                    endcase
                end
                default: begin
                    state_q      <= ST_IDLE;
                    dma_rd_q     <= 1'b0;
                    oam_we_q     <= 1'b0;
                    dma_active_q <= 1'b0;
                end
            endcase
        end
    end

    // CPU read-data return; the external bus belongs to the DMA while it runs.
    always_comb begin
        if (hit_hram_s) begin
            bus.cpu_din = hram_rdata_s;
        end else if (hit_reg_s) begin
            bus.cpu_din = src_q;
        end else if (dma_active_q) begin
            bus.cpu_din = 8'hFF;
        end else begin
            bus.cpu_din = bus.ext_din;
        end
    end

    // External bus ownership: DMA engine, silent HRAM access, or CPU passthrough.
    always_comb begin
        if (dma_active_q) begin
            bus.ext_a    = dma_addr_q;
            bus.ext_dout = 8'h00;
            bus.ext_rd   = dma_rd_q;
            bus.ext_wr   = 1'b0;
        end else if (hit_hram_s) begin
            bus.ext_a    = bus.cpu_a;
            bus.ext_dout = bus.cpu_dout;
            bus.ext_rd   = 1'b0;
            bus.ext_wr   = 1'b0;
        end else begin
            bus.ext_a    = bus.cpu_a;
            bus.ext_dout = bus.cpu_dout;
            bus.ext_rd   = bus.cpu_rd;
            bus.ext_wr   = bus.cpu_wr;
        end
    end

    assign bus.oam_a      = oam_a_q;
    assign bus.oam_dout   = oam_dout_q;
    assign bus.oam_we     = oam_we_q;
    assign bus.dma_active = dma_active_q;

endmodule
